// File: rtl/display_update_ctrl.sv
// display_update_ctrl
// Drives a MAX7219 8-digit LED driver over its 3-wire serial interface.
// After reset it sends a five-word init sequence. On each update strobe it
// sends six digit words (registers 0x01..0x06, seven-segment patterns decoded
// from BCD). An intensity word is appended when the brightness has changed.
// Strobes that arrive while busy collapse into a single pending refresh.
//
// Ports:
//   i_clk          system clock
//   i_reset_n      asynchronous active-low reset
//   i_update_stb   one-cycle refresh request
//   i_digits       six BCD nibbles, [23:20] = leftmost digit
//   i_brightness   MAX7219 intensity value
//   o_serial_dout  MAX7219 DIN
//   o_serial_clk   MAX7219 CLK
//   o_serial_load  MAX7219 LOAD/CS
//   o_busy         init or refresh sequence in progress
module display_update_ctrl #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_update_stb,
  input  logic [23:0] i_digits,
  input  logic [3:0]  i_brightness,
  output logic        o_serial_dout,
  output logic        o_serial_clk,
  output logic        o_serial_load,
  output logic        o_busy
);

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    ST_INIT     = 3'd0,
    ST_IDLE     = 3'd1,
    ST_SHIFT_LO = 3'd2,
    ST_SHIFT_HI = 3'd3,
    ST_LATCH    = 3'd4,
    ST_GAP      = 3'd5
  } state_t;

  // BCD digit to segment byte (DP=7, A=6 .. G=0); non-BCD values blank.
  function automatic logic [7:0] seg_encode(input logic [3:0] bcd);
    logic [7:0] seg;
    case (bcd)
      4'd0:    seg = 8'h7E;
      4'd1:    seg = 8'h30;
      4'd2:    seg = 8'h6D;
      4'd3:    seg = 8'h79;
      4'd4:    seg = 8'h33;
      4'd5:    seg = 8'h5B;
      4'd6:    seg = 8'h5F;
      4'd7:    seg = 8'h70;
      4'd8:    seg = 8'h7F;
      4'd9:    seg = 8'h7B;
      default: seg = 8'h00;
    endcase
    return seg;
  endfunction

  // The 16-bit word for a given position in the init or refresh sequence.
  function automatic logic [15:0] word_select(input logic       frame,
                                              input logic [2:0]  idx,
                                              input logic [23:0] digits,
                                              input logic [3:0]  bright);
    logic [15:0] word;
    logic [3:0]  nib;
    word = 16'h0000;
    nib  = 4'h0;
    if (frame) begin
      case (idx)
        3'd0:    nib = digits[23:20];
        3'd1:    nib = digits[19:16];
        3'd2:    nib = digits[15:12];
        3'd3:    nib = digits[11:8];
        3'd4:    nib = digits[7:4];
        3'd5:    nib = digits[3:0];
        default: nib = 4'h0;
      endcase
      if (idx == 3'd6) begin
        word = {8'h0A, 4'h0, bright};
      end else begin
        word = {5'b00000, idx + 3'd1, seg_encode(nib)};
      end
    end else begin
      case (idx)
        3'd0:    word = 16'h0C01;
        3'd1:    word = 16'h0F00;
        3'd2:    word = 16'h0900;
        3'd3:    word = 16'h0B05;
        3'd4:    word = {8'h0A, 4'h0, bright};
        default: word = 16'h0000;
      endcase
    end
    return word;
  endfunction

  state_t      state_q, state_d;
  logic [7:0]  div_q, div_d;
  logic [3:0]  bit_q, bit_d;
  logic [2:0]  idx_q, idx_d;
  logic [2:0]  nwords_q, nwords_d;
  logic        frame_q, frame_d;
  logic        pend_q, pend_d;
  logic [23:0] digits_q, digits_d;
  logic [3:0]  bright_q, bright_d;
  logic [3:0]  last_int_q, last_int_d;
  logic        dout_q, dout_d;
  logic        sclk_q, sclk_d;
  logic        load_q, load_d;
  logic        busy_q, busy_d;
  logic        advance_s;
  logic        start_s;
  logic        int_word_s;
  logic [15:0] out_word_s;

  // Next-state, sequencing counters and the registered-output values.
  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    bit_d      = bit_q;
    idx_d      = idx_q;
    nwords_d   = nwords_q;
    frame_d    = frame_q;
    pend_d     = pend_q;
    digits_d   = digits_q;
    bright_d   = bright_q;
    last_int_d = last_int_q;
    start_s    = 1'b0;
    advance_s  = (div_q == DIV_LAST);
    int_word_s = frame_q ? (idx_q == 3'd6) : (idx_q == 3'd4);

    if (advance_s) begin
      div_d = 8'd0;
    end else begin
      div_d = div_q + 8'd1;
    end

    // Any strobe while a sequence runs is remembered once.
    if ((state_q != ST_IDLE) && i_update_stb) begin
      pend_d = 1'b1;
    end else begin
      pend_d = pend_q;
    end

    case (state_q)
      // INIT doubles as the first low half of bit 15 of the first init word,
      // so the init sequence is exactly five word times long.
      ST_INIT: begin
        bright_d = i_brightness;
        frame_d  = 1'b0;
        nwords_d = 3'd5;
        idx_d    = 3'd0;
        bit_d    = 4'd15;
        if (advance_s) begin
          state_d = ST_SHIFT_HI;
        end else begin
          state_d = ST_SHIFT_LO;
        end
      end
      ST_IDLE: begin
        div_d = 8'd0;
        if (i_update_stb) begin
          start_s = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT_LO: begin
        if (advance_s) begin
          state_d = ST_SHIFT_HI;
        end else begin
          state_d = ST_SHIFT_LO;
        end
      end
      ST_SHIFT_HI: begin
        if (!advance_s) begin
          state_d = ST_SHIFT_HI;
        end else if (bit_q == 4'd0) begin
          state_d = ST_LATCH;
        end else begin
          state_d = ST_SHIFT_LO;
          bit_d   = bit_q - 4'd1;
        end
      end
      ST_LATCH: begin
        if (advance_s) begin
          state_d = ST_GAP;
          if (int_word_s) begin
            last_int_d = bright_q;
          end else begin
            last_int_d = last_int_q;
          end
        end else begin
          state_d = ST_LATCH;
        end
      end
      ST_GAP: begin
        if (!advance_s) begin
          state_d = ST_GAP;
        end else if (idx_q == (nwords_q - 3'd1)) begin
          // A strobe on this very cycle counts as pending, not lost.
          if (pend_q || i_update_stb) begin
            start_s = 1'b1;
          end else begin
            state_d = ST_IDLE;
            pend_d  = 1'b0;
          end
        end else begin
          state_d = ST_SHIFT_LO;
          idx_d   = idx_q + 3'd1;
          bit_d   = 4'd15;
        end
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase

    if (start_s) begin
      state_d  = ST_SHIFT_LO;
      frame_d  = 1'b1;
      idx_d    = 3'd0;
      bit_d    = 4'd15;
      div_d    = 8'd0;
      pend_d   = 1'b0;
      digits_d = i_digits;
      bright_d = i_brightness;
      nwords_d = (i_brightness != last_int_d) ? 3'd7 : 3'd6;
    end else begin
      nwords_d = nwords_d;
    end

    // Outputs are registered from the next-state values so that they line
    // up with the state register cycle for cycle.
    out_word_s = word_select(frame_d, idx_d, digits_d, bright_d);
    if ((state_d == ST_SHIFT_LO) || (state_d == ST_SHIFT_HI) ||
        (state_d == ST_INIT)) begin
      dout_d = out_word_s[bit_d];
    end else begin
      dout_d = 1'b0;
    end
    sclk_d = (state_d == ST_SHIFT_HI);
    load_d = (state_d == ST_LATCH);
    busy_d = (state_d != ST_IDLE);
  end

  // State, sequencing and output registers.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q    <= ST_INIT;
      div_q      <= 8'd0;
      bit_q      <= 4'd15;
      idx_q      <= 3'd0;
      nwords_q   <= 3'd5;
      frame_q    <= 1'b0;
      pend_q     <= 1'b0;
      digits_q   <= 24'h000000;
      bright_q   <= 4'h0;
      last_int_q <= 4'h0;
      dout_q     <= 1'b0;
      sclk_q     <= 1'b0;
      load_q     <= 1'b0;
      busy_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      bit_q      <= bit_d;
      idx_q      <= idx_d;
      nwords_q   <= nwords_d;
      frame_q    <= frame_d;
      pend_q     <= pend_d;
      digits_q   <= digits_d;
      bright_q   <= bright_d;
      last_int_q <= last_int_d;
      dout_q     <= dout_d;
      sclk_q     <= sclk_d;
      load_q     <= load_d;
      busy_q     <= busy_d;
    end
  end

  assign o_serial_dout = dout_q;
  assign o_serial_clk  = sclk_q;
  assign o_serial_load = load_q;
  assign o_busy        = busy_q;

endmodule

// File: tb/tb_display_update_ctrl.sv
// Bench for display_update_ctrl (CLK_DIV = 2). A mock MAX7219 collects every
// latched 16-bit word; frames are compared against hand-computed words.
module tb_display_update_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stb = 1'b0;
  logic [23:0] digits = 24'h000000;
  logic [3:0]  bright = 4'h8;
  logic        dout, sclk, load, busy;

  int n_checks = 0;
  int n_fail   = 0;

  display_update_ctrl #(.CLK_DIV(2)) dut (
    .i_clk        (clk),
    .i_reset_n    (rst_n),
    .i_update_stb (stb),
    .i_digits     (digits),
    .i_brightness (bright),
    .o_serial_dout(dout),
    .o_serial_clk (sclk),
    .o_serial_load(load),
    .o_busy       (busy)
  );

  always #50 clk = ~clk;

  // Mock display: shift on rising serial clock, capture on rising LOAD.
  logic [15:0] words_q[$];
  logic [15:0] sh = 16'h0000;
  int          sh_cnt = 0;
  int          bad_len = 0;
  int          bad_proto = 0;
  int          busy_cycles = 0;
  int          busy_falls = 0;
  logic        p_sclk = 1'b0, p_load = 1'b0, p_busy = 1'b1, p_dout = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      sh_cnt <= 0;
      p_sclk <= 1'b0;
      p_load <= 1'b0;
      p_busy <= 1'b1;
      p_dout <= 1'b0;
    end else begin
      if (sclk && !p_sclk) begin
        sh     <= {sh[14:0], dout};
        sh_cnt <= sh_cnt + 1;
      end
      if (load && !p_load) begin
        words_q.push_back(sh);
        if (sh_cnt != 16) bad_len <= bad_len + 1;
        sh_cnt <= 0;
      end
      if (load && sclk) bad_proto <= bad_proto + 1;
      if (sclk && p_sclk && (dout != p_dout)) bad_proto <= bad_proto + 1;
      if (busy) busy_cycles <= busy_cycles + 1;
      if (p_busy && !busy) busy_falls <= busy_falls + 1;
      p_sclk <= sclk;
      p_load <= load;
      p_busy <= busy;
      p_dout <= dout;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] word_at(input int i);
    if (i < words_q.size()) return words_q[i];
    else return 16'hxxxx;
  endfunction

  task automatic pulse();
    @(negedge clk) stb = 1'b1;
    @(negedge clk) stb = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int t;
    t = 0;
    while (busy && t < 5000) begin
      @(negedge clk);
      t++;
    end
    check({tag, "_timeout"}, {31'd0, busy}, 32'd0);
    @(negedge clk);
  endtask

  // Must be called at a negedge with reset asserted; releases and checks init.
  task automatic init_release(input string tag);
    int base, cnt;
    logic [15:0] exp [5];
    exp  = '{16'h0C01, 16'h0F00, 16'h0900, 16'h0B05, 16'h0A08};
    base = words_q.size();
    rst_n = 1'b1;
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (busy && cnt < 2000);
    check({tag, "_busy_fall"}, cnt, 32'd340);
    @(negedge clk);
    check({tag, "_nwords"}, words_q.size() - base, 32'd5);
    for (int i = 0; i < 5; i++) check({tag, "_word"}, {16'd0, word_at(base + i)}, {16'd0, exp[i]});
  endtask

  typedef struct {
    logic [23:0] digits;
    logic [3:0]  bright;
    int          n;
    logic [15:0] w [7];
  } vec_t;

  vec_t tbl [5];

  initial begin
    int base, bbase, fbase;
    logic [15:0] fr_a [6];
    logic [15:0] fr_b [6];

    tbl[0].digits = 24'h105900; tbl[0].bright = 4'h8; tbl[0].n = 6;
    tbl[0].w = '{16'h0130, 16'h027E, 16'h035B, 16'h047B, 16'h057E, 16'h067E, 16'h0000};
    tbl[1].digits = 24'h12345F; tbl[1].bright = 4'h3; tbl[1].n = 7;
    tbl[1].w = '{16'h0130, 16'h026D, 16'h0379, 16'h0433, 16'h055B, 16'h0600, 16'h0A03};
    tbl[2].digits = 24'h678900; tbl[2].bright = 4'h3; tbl[2].n = 6;
    tbl[2].w = '{16'h015F, 16'h0270, 16'h037F, 16'h047B, 16'h057E, 16'h067E, 16'h0000};
    tbl[3].digits = 24'hABCDE9; tbl[3].bright = 4'h3; tbl[3].n = 6;
    tbl[3].w = '{16'h0100, 16'h0200, 16'h0300, 16'h0400, 16'h0500, 16'h067B, 16'h0000};
    tbl[4].digits = 24'h000000; tbl[4].bright = 4'hF; tbl[4].n = 7;
    tbl[4].w = '{16'h017E, 16'h027E, 16'h037E, 16'h047E, 16'h057E, 16'h067E, 16'h0A0F};

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_dout", {31'd0, dout}, 32'd0);
    check("rst_sclk", {31'd0, sclk}, 32'd0);
    check("rst_load", {31'd0, load}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd1);

    init_release("init");

    // Table of single refresh frames started from IDLE.
    for (int i = 0; i < 5; i++) begin
      digits = tbl[i].digits;
      bright = tbl[i].bright;
      base   = words_q.size();
      bbase  = busy_cycles;
      pulse();
      check("start_busy", {31'd0, busy}, 32'd1);
      digits = ~tbl[i].digits;
      bright = ~tbl[i].bright;
      wait_idle("frame");
      check("frame_cycles", busy_cycles - bbase, tbl[i].n * 68);
      check("frame_nwords", words_q.size() - base, tbl[i].n);
      for (int k = 0; k < tbl[i].n; k++)
        check("frame_word", {16'd0, word_at(base + k)}, {16'd0, tbl[i].w[k]});
    end

    // Three strobes during one frame: exactly one back-to-back extra frame.
    fr_a = '{16'h016D, 16'h0279, 16'h035B, 16'h047B, 16'h055B, 16'h067B};
    fr_b = '{16'h017E, 16'h027E, 16'h037E, 16'h047E, 16'h057E, 16'h0630};
    digits = 24'h235959;
    bright = 4'hF;
    base  = words_q.size();
    bbase = busy_cycles;
    fbase = busy_falls;
    pulse();
    repeat (50) @(negedge clk);
    digits = 24'h000001;
    pulse();
    repeat (100) @(negedge clk);
    pulse();
    repeat (100) @(negedge clk);
    pulse();
    wait_idle("pend");
    check("pend_cycles", busy_cycles - bbase, 32'd816);
    check("pend_falls", busy_falls - fbase, 32'd1);
    check("pend_nwords", words_q.size() - base, 32'd12);
    for (int k = 0; k < 6; k++) begin
      check("pend_word_a", {16'd0, word_at(base + k)}, {16'd0, fr_a[k]});
      check("pend_word_b", {16'd0, word_at(base + 6 + k)}, {16'd0, fr_b[k]});
    end
    repeat (300) @(negedge clk);
    check("pend_no_third", words_q.size() - base, 32'd12);
    check("pend_idle", {31'd0, busy}, 32'd0);

    // Strobe on the final GAP cycle becomes a back-to-back frame.
    base  = words_q.size();
    bbase = busy_cycles;
    fbase = busy_falls;
    pulse();
    repeat (407) @(negedge clk);
    stb = 1'b1;
    @(negedge clk) stb = 1'b0;
    wait_idle("gap");
    check("gap_cycles", busy_cycles - bbase, 32'd816);
    check("gap_falls", busy_falls - fbase, 32'd1);
    check("gap_nwords", words_q.size() - base, 32'd12);
    for (int k = 0; k < 12; k++)
      check("gap_word", {16'd0, word_at(base + k)}, {16'd0, fr_b[k % 6]});

    // Reset in the middle of bit 7 of the third init word.
    bright = 4'h8;
    @(negedge clk) rst_n = 1'b0;
    repeat (3) @(negedge clk);
    base  = words_q.size();
    rst_n = 1'b1;
    repeat (170) @(posedge clk);
    #10;
    check("mid_sclk_hi", {31'd0, sclk}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_dout", {31'd0, dout}, 32'd0);
    check("mid_sclk", {31'd0, sclk}, 32'd0);
    check("mid_load", {31'd0, load}, 32'd0);
    check("mid_busy", {31'd0, busy}, 32'd1);
    repeat (4) @(negedge clk);
    check("mid_nwords", words_q.size() - base, 32'd2);
    check("mid_hold_load", {31'd0, load}, 32'd0);
    init_release("reinit");

    check("word_len", bad_len, 32'd0);
    check("protocol", bad_proto, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
